// File: rtl/lector_contador_pkg.sv
// Shared definitions for the contador read-back scanner.
// State encoding, widths and scan limits.
package lector_contador_pkg;

    localparam int NUM_COUNTERS = 5;
    localparam int COUNT_WIDTH  = 5;
    localparam int IDX_WIDTH    = 3;
    localparam int TOTAL_WIDTH  = 8;
    localparam int TIMEOUT      = 7;
    localparam int TMO_WIDTH    = 3;
    localparam int SNAP_WIDTH   = NUM_COUNTERS * COUNT_WIDTH;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX =
        IDX_WIDTH'(NUM_COUNTERS - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_IDLE  = 3'd1,
        S_REQ        = 3'd2,
        S_WAIT_VALID = 3'd3,
        S_DONE       = 3'd4
    } state_t;

endpackage

// File: rtl/lector_timeout.sv
// Response watchdog: loaded when a request goes out,
// counts down while waiting and flags expiry.
module lector_timeout
    import lector_contador_pkg::*;
(
    input  logic clk,
    input  logic reset_L,
    input  logic clear,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam logic [TMO_WIDTH-1:0] LOAD_VAL =
        TMO_WIDTH'(TIMEOUT - 1);

    logic [TMO_WIDTH-1:0] cnt;

    // Remaining wait cycles; reaches zero on the last allowed cycle.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = en && (cnt == '0);

endmodule

// File: rtl/lector_contador.sv
// Scans the five contador pop counts once the FIFOs are idle,
// sums them and compares with the injected word count.
module lector_contador
    import lector_contador_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic                   start,
    input  logic                   idle,
    input  logic [COUNT_WIDTH-1:0] data_in,
    input  logic                   valid_in,
    input  logic [TOTAL_WIDTH-1:0] expected_total,
    output logic                   req,
    output logic [IDX_WIDTH-1:0]   idx,
    output logic [SNAP_WIDTH-1:0]  snapshot,
    output logic [TOTAL_WIDTH-1:0] total,
    output logic                   busy,
    output logic                   done,
    output logic                   match,
    output logic                   timeout_err
);

    state_t                 state;
    state_t                 state_nx;
    logic [TOTAL_WIDTH-1:0] exp_q;
    logic [TOTAL_WIDTH-1:0] total_nx;
    logic                   accept_start;
    logic                   abort;
    logic                   capture;
    logic                   expire;
    logic                   advance;
    logic                   last;
    logic                   in_wait;

    assign in_wait      = (state == S_WAIT_VALID);
    assign accept_start = start &&
                          (state == S_IDLE || state == S_DONE);
    assign abort        = !idle &&
                          (state == S_REQ || in_wait);
    assign capture      = in_wait && idle && valid_in;
    assign advance      = in_wait && idle && (valid_in || expire);
    assign last         = (idx == LAST_IDX);
    assign total_nx     = total + TOTAL_WIDTH'(data_in);

    assign req  = (state == S_REQ);
    assign busy = !(state == S_IDLE || state == S_DONE);

    lector_timeout u_timeout (
        .clk     (clk),
        .reset_L (reset_L),
        .clear   (accept_start || abort),
        .load    (state == S_REQ),
        .en      (in_wait),
        .expire  (expire)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state selection; an idle drop always wins.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nx = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (idle) state_nx = S_REQ;
            end
            S_REQ: begin
                state_nx = idle ? S_WAIT_VALID : S_WAIT_IDLE;
            end
            S_WAIT_VALID: begin
                if (!idle) begin
                    state_nx = S_WAIT_IDLE;
                end else if (advance) begin
                    state_nx = last ? S_DONE : S_REQ;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Scan datapath: index, snapshot slots, running sum and result.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            idx         <= '0;
            snapshot    <= '0;
            total       <= '0;
            done        <= 1'b0;
            match       <= 1'b0;
            timeout_err <= 1'b0;
            exp_q       <= '0;
        end else begin
            done <= 1'b0;
            if (accept_start) begin
                idx         <= '0;
                snapshot    <= '0;
                total       <= '0;
                match       <= 1'b0;
                timeout_err <= 1'b0;
                exp_q       <= expected_total;
            end else if (abort) begin
                idx      <= '0;
                snapshot <= '0;
                total    <= '0;
            end else if (advance) begin
                if (capture) begin
                    for (int k = 0; k < NUM_COUNTERS; k++) begin
                        if (idx == IDX_WIDTH'(k)) begin
                            snapshot[k*COUNT_WIDTH +: COUNT_WIDTH]
                                <= data_in;
                        end
                    end
                    total <= total_nx;
                end else begin
                    timeout_err <= 1'b1;
                end
                if (last) begin
                    idx   <= '0;
                    done  <= 1'b1;
                    match <= capture && !timeout_err &&
                             (total_nx == exp_q);
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/lector_contador.md
Name: lector_contador

Overview:
- Downstream consumer of the pop counter (contador) in the egress path.
- Once the FIFO system reports idle, it sequentially requests the pop count of each of the five output FIFOs and captures each value into a snapshot register.
- Sums the captured counts and compares the sum with the number of words the ingress side injected.
- Gives the testbench/top level one end-of-test pass/fail result.

Parameters:
- NUM_COUNTERS, 5, number of output FIFOs/counters scanned (idx 0..NUM_COUNTERS-1).
- COUNT_WIDTH, 5, width of each counter value from contador.
- IDX_WIDTH, 3, width of idx.
- TOTAL_WIDTH, 8, width of accumulated total (holds 5*31=155).
- TIMEOUT, 7, cycles to wait for valid after a req before declaring a timeout.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_L  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a scan; ignored while busy.
- idle  input  1  system idle (all FIFOs empty), same signal that feeds contador.
- data_in  input  COUNT_WIDTH  count value from contador data_out.
- valid_in  input  1  contador valid.
- expected_total  input  TOTAL_WIDTH  words injected upstream; sampled on accepted start.
- req  output  1  read request to contador.
- idx  output  IDX_WIDTH  counter index to contador.
- snapshot  output  NUM_COUNTERS*COUNT_WIDTH  captured counts; slot k at bits [k*COUNT_WIDTH +: COUNT_WIDTH].
- total  output  TOTAL_WIDTH  sum of captured counts.
- busy  output  1  high in every state except S_IDLE and S_DONE.
- done  output  1  one-cycle pulse when a scan completes.
- match  output  1  total==expected_total and no timeout; valid from done, held until next accepted start.
- timeout_err  output  1  sticky: some counter did not answer within TIMEOUT; cleared on accepted start.

Behaviour:
- Reset (async, reset_L=0):
  - State S_IDLE.
  - req=0, idx=0, snapshot=0, total=0, busy=0, done=0, match=0, timeout_err=0.
  - Timeout counter=0, expected register=0.
- States: S_IDLE, S_WAIT_IDLE, S_REQ, S_WAIT_VALID, S_DONE.
- S_IDLE / S_DONE + start=1:
  - Clear snapshot, total, match, timeout_err; idx=0; latch expected_total.
  - Go to S_WAIT_IDLE.
- S_WAIT_IDLE: stay while idle=0; idle=1 -> S_REQ.
- S_REQ:
  - req=1 for exactly this one cycle with current idx.
  - Timeout counter=0; next state S_WAIT_VALID.
- S_WAIT_VALID, req=0:
  - valid_in=1: write data_in into slot idx, total += zero-extended data_in.
    - idx==NUM_COUNTERS-1 -> S_DONE.
    - Otherwise idx+1 -> S_REQ.
  - Timeout counter reaches TIMEOUT with no valid: timeout_err=1, slot stays 0, then advance exactly as for a capture.
  - contador answers one cycle after req, so a nominal scan is 2 cycles per counter.
- S_DONE entry:
  - done=1 for one cycle.
  - match computed from the final total; idx returns to 0.
  - Stay in S_DONE until start.
- Idle drop: idle falling to 0 in S_REQ or S_WAIT_VALID aborts the scan. Clear snapshot and total, idx=0, return to S_WAIT_IDLE; timeout_err kept.
- Simultaneous events:
  - valid_in and idle drop in the same cycle: abort wins, capture discarded.
  - valid_in outside S_WAIT_VALID: ignored.
- start while busy is ignored, with no effect on any register.
- Reset asserted mid-scan returns immediately to the reset values; no done pulse.
- Arithmetic: total is unsigned, no saturation needed (max 155 < 256). expected_total compares all TOTAL_WIDTH bits.

Decomposition:
- Shared package/header contains:
  - state encodings S_IDLE..S_DONE (3-bit);
  - NUM_COUNTERS, COUNT_WIDTH, IDX_WIDTH;
  - the same defines contador uses for idx width.
- One sub-module is natural: lector_timeout, a loadable down-counter with clear/expire, instantiated once.
- Everything else stays in the top FSM.
- Provide a conductual version and a Yosys-synthesised lector_contador_synth.
- Bench compares the two cycle by cycle, as for contador.

Test Plan:
- Nominal: contador counts pop0..pop4 = 3,1,4,1,5; expected_total=14; start with idle=1 -> req pulses at idx 0..4 two cycles apart, snapshot slots 3,1,4,1,5, total=14, done pulse, match=1.
- Mismatch: same counts, expected_total=15 -> done pulse, total=14, match=0, timeout_err=0.
- Wait for idle: start while idle=0 for 10 cycles -> no req until idle=1; first req on idx=0 the cycle after S_REQ is entered.
- Abort: idle drops while waiting valid on idx=2 -> snapshot and total cleared, no done; idle returns -> scan restarts at idx=0 and completes with correct values.
- Timeout: valid_in forced 0 for idx=3 -> after 7 cycles timeout_err=1, slot3=0, scan continues to idx=4, done with match=0.
- Reset/start misuse: start pulse during busy ignored; reset_L low mid-scan -> all outputs 0 same edge; conductual and synth outputs identical throughout.
